// File: rtl/ics_mem_pkg.sv
// Shared types and helpers for the ICS2115 sample-fetch path.
package ics_mem_pkg;

  localparam int ICS_ADDR_W = 29;
  localparam int ICS_LINE_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } fetch_state_t;

  // Rotate a 64-bit line right by whole 16-bit lanes so the chosen lane lands in bits [15:0].
  function automatic logic [ICS_LINE_W-1:0] rot16(input logic [ICS_LINE_W-1:0] line,
                                                  input logic [1:0]            lane);
    logic [2*ICS_LINE_W-1:0] dbl;
    dbl = {line, line} >> {lane, 4'b0000};
    return dbl[ICS_LINE_W-1:0];
  endfunction

endpackage

// File: rtl/ics_sample_line_cache.sv
// One-line sample cache: tag, valid bit and raw (unrotated) line data with hit compare.
module ics_sample_line_cache
  import ics_mem_pkg::*;
#(
  parameter int TAG_W  = ICS_ADDR_W - 3,
  parameter int DATA_W = ICS_LINE_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [TAG_W-1:0]  lookup_tag,
  input  logic              inv,
  input  logic              fill,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data,
  output logic              hit,
  output logic [DATA_W-1:0] data
);

  logic              valid_r;
  logic [TAG_W-1:0]  tag_r;
  logic [DATA_W-1:0] data_r;

  // Invalidate wins over a same-cycle fill so rewritten sample RAM is never shadowed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      tag_r   <= '0;
      data_r  <= '0;
    end else if (inv) begin
      valid_r <= 1'b0;
    end else if (fill) begin
      valid_r <= 1'b1;
      tag_r   <= fill_tag;
      data_r  <= fill_data;
    end
  end

  assign hit  = valid_r & (tag_r == lookup_tag) & ~inv;
  assign data = data_r;

endmodule

// File: rtl/ics_sample_fetch.sv
// ICS2115 sample-read responder: line-aligned SDRAM fetch with 16-bit lane rotation.
// Optional one-line cache enabled by defining ICS_SAMPLE_CACHE_EN.
module ics_sample_fetch
  import ics_mem_pkg::*;
#(
  parameter int ADDR_W  = ICS_ADDR_W,
  parameter int DATA_W  = ICS_LINE_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_rd,
  input  logic [ADDR_W-1:0] req_addr,
  output logic [DATA_W-1:0] req_dout,
  output logic              req_busy,
  output logic              req_dout_ready,
  output logic              req_err,
  input  logic              inv,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_busy,
  input  logic [DATA_W-1:0] mem_dout,
  input  logic              mem_ack
);

  localparam int              CNT_W   = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  fetch_state_t      state_r;
  fetch_state_t      state_nxt_s;
  logic              armed_r;
  logic [CNT_W-1:0]  cnt_r;
  logic [ADDR_W-1:1] addr_r;
  logic              accept_s;
  logic              hit_s;
  logic [DATA_W-1:0] hit_data_s;

  assign accept_s = (state_r == IDLE) & req_rd & armed_r;

`ifdef ICS_SAMPLE_CACHE_EN
  logic fill_s;
  logic inv_seen_r;
  logic unused_s;

  ics_sample_line_cache #(
    .TAG_W  (ADDR_W - 3),
    .DATA_W (DATA_W)
  ) u_cache (
    .clk        (clk),
    .reset_n    (reset_n),
    .lookup_tag (req_addr[ADDR_W-1:3]),
    .inv        (inv),
    .fill       (fill_s),
    .fill_tag   (addr_r[ADDR_W-1:3]),
    .fill_data  (mem_dout),
    .hit        (hit_s),
    .data       (hit_data_s)
  );

  // A line fetched while an invalidate was pending may be stale, so it is returned but not cached.
  assign fill_s = (state_r == WAIT) & mem_ack & ~inv_seen_r & ~inv;

  // Track invalidates that arrive while a miss is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inv_seen_r <= 1'b0;
    end else if (accept_s) begin
      inv_seen_r <= 1'b0;
    end else if (inv && ((state_r == ISSUE) || (state_r == WAIT))) begin
      inv_seen_r <= 1'b1;
    end
  end

  assign unused_s = req_addr[0];
`else
  logic unused_s;

  assign hit_s      = 1'b0;
  assign hit_data_s = '0;
  assign unused_s   = ^{inv, req_addr[0], addr_r[ADDR_W-1:3]};
`endif

  // Next-state decode; a timed-out WAIT still goes to RESP, flagged by req_err.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_nxt_s = hit_s ? RESP : ISSUE;
        else          state_nxt_s = IDLE;
      end
      ISSUE: begin
        if (!mem_busy) state_nxt_s = WAIT;
        else           state_nxt_s = ISSUE;
      end
      WAIT: begin
        if (mem_ack || (cnt_r == CNT_MAX)) state_nxt_s = RESP;
        else                               state_nxt_s = WAIT;
      end
      RESP:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, handshake outputs (decoded from next state so they are registered) and response data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r        <= IDLE;
      armed_r        <= 1'b1;
      cnt_r          <= '0;
      addr_r         <= '0;
      mem_addr       <= '0;
      mem_rd         <= 1'b0;
      req_busy       <= 1'b0;
      req_dout_ready <= 1'b0;
      req_err        <= 1'b0;
      req_dout       <= '0;
    end else begin
      state_r        <= state_nxt_s;
      req_busy       <= (state_nxt_s != IDLE);
      mem_rd         <= (state_nxt_s == ISSUE);
      req_dout_ready <= (state_nxt_s == RESP);

      // A still-high request must drop for a cycle before it can be served again.
      if (accept_s)     armed_r <= 1'b0;
      else if (!req_rd) armed_r <= 1'b1;

      if ((state_r == WAIT) && (state_nxt_s == WAIT)) cnt_r <= cnt_r + CNT_W'(1);
      else                                            cnt_r <= '0;

      if (accept_s) begin
        addr_r  <= req_addr[ADDR_W-1:1];
        req_err <= 1'b0;
        if (hit_s) req_dout <= rot16(hit_data_s, req_addr[2:1]);
        else       mem_addr <= {req_addr[ADDR_W-1:3], 3'b000};
      end else if (state_r == WAIT) begin
        if (mem_ack) begin
          req_dout <= rot16(mem_dout, addr_r[2:1]);
        end else if (cnt_r == CNT_MAX) begin
          req_dout <= '0;
          req_err  <= 1'b1;
        end
      end
    end
  end

endmodule
